spi_master_gen: RTL and testbench
=================================

Name: spi_master_gen

Overview:
- Parametrised SPI master: the next generation of the team's single-mode 8-bit SPI master.
- Adds configurable word width, all four SPI modes (CPOL/CPHA) selected per transfer, and multiple slave selects.
- Adds a ready/start handshake with a one-cycle done pulse.
- Sits between a processor-side register interface and the external SPI pins.

Parameters:
- DATA_W, 8: bits per transfer, >=2.
- NUM_SS, 1: number of slave-select lines, >=1.
- CLK_DIV, 8: SCLK period in clk cycles; even, >=2. H = CLK_DIV/2 is the half period.
- SS_W, 1: width of ss_sel; must satisfy 2**SS_W >= NUM_SS.

Ports:
- clk  in  1  processor clock
- rst  in  1  reset: synchronous, active-high; single clock domain
- data_in  in  DATA_W  word to transmit
- ss_sel  in  SS_W  index of the slave to select
- cpol  in  1  SCLK idle level
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
- start  in  1  transfer request
- ready  out  1  master can accept start
- busy  out  1  transfer in progress (equals !ready)
- data_out  out  DATA_W  last received word
- done  out  1  one-cycle pulse, data_out valid
- miso  in  1  master in slave out
- mosi  out  1  master out slave in
- sclk  out  1  SPI clock
- ss_n  out  NUM_SS  active-low slave selects

Behaviour:
- Reset values:
  - ready=1, busy=0, done=0, data_out=0, mosi=0, sclk=0, ss_n=all 1s.
  - Latched mode cpol_r=0, cpha_r=0; state=IDLE.
- Handshake:
  - Transfer is accepted when start && ready on a rising clk edge.
  - data_in, ss_sel, cpol and cpha are latched at acceptance.
  - Inputs are ignored while busy; start while busy is dropped, not queued.
- FSM IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE: sclk=cpol_r; ss_n all high; ready=1.
- SETUP, H cycles:
  - ss_n[ss_sel] driven low; sclk stays idle.
  - CPHA=0: mosi = first bit during SETUP.
- XFER, 2*DATA_W*H cycles:
  - sclk toggles every H cycles, starting from the idle level; DATA_W full periods.
  - CPHA=0: sample miso on leading edges; shift mosi to the next bit on trailing edges, except after the last bit.
  - CPHA=1: shift mosi on leading edges, the first shift presenting the first bit; sample miso on trailing edges.
  - Bit order is MSB first.
- HOLD, H cycles: sclk idle, ss_n still asserted.
- Return to IDLE:
  - Return is on the clk edge ending HOLD.
  - In that first IDLE cycle: done=1, data_out = received word, ss_n released, ready=1.
- Latency: acceptance edge to done asserted = (2*DATA_W+2)*H cycles. DATA_W=8, CLK_DIV=8 gives 72.
- Back-to-back: start may be high in the done cycle; the new transfer is accepted on that edge.
- Counters:
  - Half-period counter wraps at H-1.
  - Bit counter is clog2(DATA_W)+1 bits wide and counts down to 0; no wrap beyond.
- ss_sel >= NUM_SS: the transfer runs normally with all ss_n high (dummy clocks); done still pulses.
- rst mid-transfer:
  - All outputs return to reset values on the next edge; no done pulse.
  - data_out is cleared to 0.
- mosi: holds its last value in IDLE.

Optional Feature:
- SPI_LSB_FIRST_EN defined:
  - Extra input port lsb_first (1 bit), latched at acceptance.
  - When 1, shifting and sampling run LSB first.
  - data_out is reassembled so bit i equals the i-th received bit; word value is identical to the MSB-first case for a bit-reversed slave.
- Not defined: no lsb_first port; always MSB first.

Decomposition:
- Shared include spi_defs.vh holds:
  - FSM state encodings: IDLE=2'd0, SETUP=2'd1, XFER=2'd2, HOLD=2'd3.
  - Mode constants SPI_MODE0..3 as {cpol,cpha}.
- One sub-module, spi_clk_gen:
  - Half-period tick counter parameterised by CLK_DIV.
  - Outputs a single-cycle tick every H clk cycles while enabled; restarts at 0 when enabled rises.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=8; send 0xA5 while the slave model returns 0x3C.
  - mosi bits 1,0,1,0,0,1,0,1 sampled on sclk rising edges.
  - data_out=0x3C with done at acceptance+72 cycles; ss_n[0] low for exactly 72 cycles.
- Mode 3 (cpol=1, cpha=1); send 0x81, slave returns 0xFF.
  - sclk idles high; miso is sampled on rising (trailing) edges.
  - data_out=0xFF; sclk back high before ss_n releases.
- NUM_SS=4, ss_sel=2, mode 1.
  - Only ss_n[2] goes low; ss_n=4'b1011 throughout.
- ss_sel=5 with NUM_SS=4.
  - ss_n stays 4'b1111; 8 clocks issued; done pulses.
- start held high continuously.
  - Second transfer accepted in the done cycle; ready high for exactly one cycle between transfers.
- rst asserted mid-XFER at bit 4.
  - Next edge: ss_n all high, sclk=0, busy=0, data_out=0, no done pulse.

Source files
------------

// File: rtl/spi_master_gen_pkg.sv
// Shared definitions for the spi_master_gen SPI master: FSM state encodings,
// SPI mode constants ({cpol,cpha}) and a counter-width helper.
package spi_master_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // A one-state counter still needs a 1-bit register.
  function automatic int cnt_width(input int h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

endpackage

// File: rtl/spi_master_gen_clk_gen.sv
// Half-period tick generator: one-cycle tick every CLK_DIV/2 clocks while
// enabled; the count restarts from 0 each time the enable rises.
module spi_clk_gen
  import spi_master_gen_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int H  = CLK_DIV / 2;
  localparam int CW = cnt_width(H);
  localparam logic [CW-1:0] LAST = CW'(H - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d  = '0;
    tick_o = 1'b0;
    if (en_i) begin
      tick_o = (cnt_q == LAST);
      cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: configurable word width, per-transfer CPOL/CPHA,
// NUM_SS slave selects, start/ready handshake and one-cycle done pulse.
// Optional macro SPI_LSB_FIRST_EN adds an lsb_first input (LSB-first shifting).
module spi_master_gen
  import spi_master_gen_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 1,
  parameter int CLK_DIV = 8,
  parameter int SS_W    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              start,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_SS-1:0] ss_n,
  output logic [1:0]        state_dbg
);

  localparam int BCW = $clog2(DATA_W) + 1;
  localparam logic [BCW-1:0] BITS = BCW'(DATA_W);
  localparam logic [BCW-1:0] ONE  = BCW'(1);

  // Handshake: a transfer is accepted on a rising clk edge with start && ready;
  // ready stays low until the first cycle after HOLD, and start while busy is dropped.

  state_e            state_q, state_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              mosi_q, mosi_d;
  logic              sclk_q, sclk_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              done_q, done_d;
  logic              tick;
  logic              lead;
  logic              lsb_in;
  logic              lsb_mode;

`ifdef SPI_LSB_FIRST_EN
  logic lsb_q, lsb_d;
  assign lsb_in   = lsb_first;
  assign lsb_mode = lsb_q;
  always_comb begin
    lsb_d = lsb_q;
    if (state_q == ST_IDLE && start) lsb_d = lsb_first;
  end
  always_ff @(posedge clk) begin
    if (rst) lsb_q <= 1'b0;
    else     lsb_q <= lsb_d;
  end
`else
  assign lsb_in   = 1'b0;
  assign lsb_mode = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // LSB-first reception fills from the top so bit i ends up as the i-th received bit.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  function automatic logic [NUM_SS-1:0] sel_mask(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_SS; i++) m[i] = (sel != SS_W'(i));
    return m;
  endfunction

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  // A toggle away from the idle level is a leading edge.
  assign lead = (sclk_q == cpol_q);

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          cpol_d    = cpol;
          cpha_d    = cpha;
          sclk_d    = cpol;
          ss_n_d    = sel_mask(ss_sel);
          bit_cnt_d = BITS;
          rx_d      = '0;
          tx_d      = data_in;
          if (!cpha) begin
            mosi_d = first_bit(data_in, lsb_in);
            tx_d   = shift_out(data_in, lsb_in);
          end
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (lead) begin
            if (cpha_q) begin
              mosi_d = first_bit(tx_q, lsb_mode);
              tx_d   = shift_out(tx_q, lsb_mode);
            end else begin
              rx_d = shift_in(rx_q, miso, lsb_mode);
            end
          end else begin
            if (cpha_q) begin
              rx_d = shift_in(rx_q, miso, lsb_mode);
            end else if (bit_cnt_q != ONE) begin
              mosi_d = first_bit(tx_q, lsb_mode);
              tx_d   = shift_out(tx_q, lsb_mode);
            end
            bit_cnt_d = bit_cnt_q - ONE;
            if (bit_cnt_q == ONE) state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          data_out_d = rx_q;
          ss_n_d     = '1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      ss_n_q     <= '1;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign busy      = ~ready;
  assign data_out  = data_out_q;
  assign done      = done_q;
  assign mosi      = mosi_q;
  assign sclk      = sclk_q;
  assign ss_n      = ss_n_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen (DATA_W=8, NUM_SS=4, CLK_DIV=8, SS_W=3): a
// cycle-position model of the transfer timeline plus directed literal checks.
module tb_spi_master_gen;
  import spi_master_gen_pkg::*;

  localparam int D   = 8;
  localparam int NSS = 4;
  localparam int DIV = 8;
  localparam int SSW = 3;
  localparam int H   = DIV / 2;
  localparam int LAT = (2 * D + 2) * H;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [D-1:0]   data_in = '0;
  logic [SSW-1:0] ss_sel = '0;
  logic           cpol = 1'b0;
  logic           cpha = 1'b0;
  logic           start = 1'b0;
  logic           lsb_first = 1'b0;
  logic           miso = 1'b0;
  logic           ready, busy, done, mosi, sclk;
  logic [D-1:0]   data_out;
  logic [NSS-1:0] ss_n;
  logic [1:0]     state_dbg;

  spi_master_gen #(.DATA_W(D), .NUM_SS(NSS), .CLK_DIV(DIV), .SS_W(SSW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .ss_sel    (ss_sel),
    .cpol      (cpol),
    .cpha      (cpha),
    .start     (start),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .ready     (ready),
    .busy      (busy),
    .data_out  (data_out),
    .done      (done),
    .miso      (miso),
    .mosi      (mosi),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .state_dbg (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position m_c (edges since acceptance) defines the whole waveform.
  logic [D-1:0]   exp_q[$];
  logic [D-1:0]   slave_word = '0;
  bit             m_busy = 1'b0;
  bit             m_done = 1'b0;
  int             m_c = 0;
  logic [D-1:0]   m_data = '0;
  logic [D-1:0]   m_s = '0;
  logic [D-1:0]   m_dout = '0;
  logic           m_cpol = 1'b0;
  logic           m_cpha = 1'b0;
  logic           m_mosi = 1'b0;
  logic [NSS-1:0] m_mask = '1;

  function automatic logic [NSS-1:0] exp_mask(input int sel);
    if (sel < NSS) return ~(NSS'(1) << sel);
    return '1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_c = 0; m_cpol = 0; m_cpha = 0;
      m_dout = '0; m_mosi = 0; m_mask = '1;
      exp_q.delete();
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_c++;
        if (m_c == LAT) begin
          m_busy = 0;
          m_done = 1;
          m_dout = exp_q.pop_front();
          m_mosi = m_data[0];
        end
      end else if (start) begin
        m_busy = 1; m_c = 0;
        m_data = data_in; m_s = slave_word;
        m_cpol = cpol; m_cpha = cpha;
        m_mask = exp_mask(int'(ss_sel));
        exp_q.push_back(slave_word);
      end
    end
  end

  // observer counters, cleared by the driver between tests
  logic       prev_sclk = 1'b0;
  int         rise_cnt = 0, ss0_low = 0, ssn1011 = 0, done_cnt = 0, ready_cnt = 0;
  logic [7:0] mosi_cap = '0;
  logic [3:0] ss_and = '1;

  always @(negedge clk) begin : cmp_blk
    int n, k, m;
    logic e_sclk, e_mosi;
    bit mosi_def;
    n = 0;
    if (m_busy && m_c >= 2 * H) n = (m_c / H - 1 > 2 * D) ? 2 * D : m_c / H - 1;
    e_sclk = m_cpol ^ (n % 2 == 1);
    mosi_def = 0;
    e_mosi = 1'b0;
    if (!m_busy) begin
      mosi_def = 1; e_mosi = m_mosi;
    end else if (m_c >= 2 * H && m_c % H == 0 && m_c / H - 1 <= 2 * D) begin
      k = m_c / H - 1;
      if ((k % 2 == 1) != m_cpha) begin
        mosi_def = 1; e_mosi = m_data[D - 1 - (k - 1) / 2];
      end
    end
    if (cmp_en) begin
      chk("ready", ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("data_out", data_out, m_dout);
      chk("ss_n", ss_n, m_busy ? m_mask : 4'hF);
      chk("sclk", sclk, e_sclk);
      if (mosi_def) chk("mosi", mosi, e_mosi);
    end
    if (!prev_sclk && sclk) begin
      rise_cnt++;
      mosi_cap = {mosi_cap[6:0], mosi};
    end
    prev_sclk = sclk;
    ss0_low   += (ss_n[0] == 1'b0) ? 1 : 0;
    ssn1011   += (ss_n == 4'b1011) ? 1 : 0;
    ss_and    &= ss_n;
    done_cnt  += (done == 1'b1) ? 1 : 0;
    ready_cnt += (ready == 1'b1) ? 1 : 0;
    // slave: present the bit for the next master sample
    m = 0;
    if (m_busy) m = m_cpha ? n / 2 : (n + 1) / 2;
    miso = (m_busy && m < D) ? m_s[D - 1 - m] : 1'b0;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_obs();
    rise_cnt = 0; ss0_low = 0; ssn1011 = 0; done_cnt = 0; ready_cnt = 0;
    mosi_cap = '0; ss_and = '1; prev_sclk = sclk;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      step();
      lat++;
      if (done === 1'b1) break;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run_xfer(input logic [D-1:0] d, input logic [D-1:0] s, input int sel,
                          input logic [1:0] mode, output int lat);
    data_in = d; slave_word = s; ss_sel = SSW'(sel);
    {cpol, cpha} = mode;
    start = 1'b1;
    step();
    start = 1'b0;
    clr_obs();
    data_in = ~d; ss_sel = SSW'($urandom_range(0, 7)); cpol = ~mode[1]; cpha = ~mode[0];
    wait_done(lat);
  endtask

  initial begin : main
    int lat, lat2;
    rst = 1'b1;
    repeat (3) step();
    cmp_en = 1'b1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_ss_n", ss_n, 4'hF);
    chk("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    repeat (2) step();

    // mode 0: send 0xA5, slave returns 0x3C
    run_xfer(8'hA5, 8'h3C, 0, SPI_MODE0, lat);
    chk("m0_latency", lat, 72);
    chk("m0_data_out", data_out, 8'h3C);
    chk("m0_mosi_bits", mosi_cap, 8'hA5);
    chk("m0_rises", rise_cnt, 8);
    chk("m0_ss0_low", ss0_low, 72);
    repeat (3) step();

    // mode 3: send 0x81, slave returns 0xFF
    run_xfer(8'h81, 8'hFF, 0, SPI_MODE3, lat);
    chk("m3_latency", lat, 72);
    chk("m3_data_out", data_out, 8'hFF);
    chk("m3_mosi_bits", mosi_cap, 8'h81);
    chk("m3_rises", rise_cnt, 8);
    chk("m3_sclk_idle", sclk, 1);
    repeat (3) step();

    // mode 1 on slave 2
    run_xfer(8'h5A, 8'hC3, 2, SPI_MODE1, lat);
    chk("sel2_data_out", data_out, 8'hC3);
    chk("sel2_ss_cycles", ssn1011, 72);
    chk("sel2_ss_and", ss_and, 4'b1011);
    chk("sel2_mosi_bits", mosi_cap, 8'h5A);
    repeat (3) step();

    // out-of-range select: dummy clocks only
    run_xfer(8'h12, 8'h96, 5, SPI_MODE0, lat);
    step();
    chk("sel5_ss_and", ss_and, 4'hF);
    chk("sel5_rises", rise_cnt, 8);
    chk("sel5_done_cnt", done_cnt, 1);
    chk("sel5_data_out", data_out, 8'h96);
    repeat (3) step();

    // start held high: second transfer accepted in the done cycle
    data_in = 8'h33; slave_word = 8'h6D; ss_sel = 3'd1; {cpol, cpha} = SPI_MODE2;
    start = 1'b1;
    step();
    clr_obs();
    wait_done(lat);
    chk("b2b_lat1", lat, 72);
    ready_cnt = 0;
    done_cnt = 0;
    wait_done(lat2);
    start = 1'b0;
    chk("b2b_lat2", lat2, 73);
    chk("b2b_ready_gap", ready_cnt, 1);
    step();
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_data_out", data_out, 8'h6D);
    repeat (3) step();

    // reset in the middle of XFER
    data_in = 8'hC6; slave_word = 8'h5A; ss_sel = 3'd1; {cpol, cpha} = SPI_MODE2;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (45) step();
    chk("pre_rst_sclk", sclk, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_ss_n", ss_n, 4'hF);
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_done", done, 0);
    rst = 1'b0;
    clr_obs();
    repeat (100) step();
    chk("post_rst_done_cnt", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
